// File: rtl/muldiv_unit_if.sv
// RV32M operation encoding and the core-side request/response bundle of the mul/div unit.
package muldiv_unit_pkg;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_e;

endpackage

interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    import muldiv_unit_pkg::*;

    logic            start;
    alu_op_e         alu_op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, alu_op, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, alu_op, rs1, rs2, flush,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_unit.sv
// RV32M execution unit: one-cycle registered multiply, restoring radix-2 divider.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);

    localparam int unsigned     PW       = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_e;

    state_e          state_q,  state_d;
    alu_op_e         op_q,     op_d;
    logic [XLEN-1:0] a_q,      a_d;
    logic [XLEN-1:0] b_q,      b_d;
    logic [XLEN-1:0] quo_q,    quo_d;
    logic [XLEN-1:0] rem_q,    rem_d;
    logic [XLEN-1:0] dvs_q,    dvs_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q;
    logic            done_q;

    logic            in_mul;
    logic            in_div;
    logic            in_sgn;
    logic            in_quo;
    logic            op_sgn;
    logic            op_quo;
    logic            q_neg;
    logic            r_neg;
    logic signed [XLEN:0] mul_a;
    logic signed [XLEN:0] mul_b;
    logic [PW-1:0]   prod;
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;

    // Opcode classification of the incoming request and of the latched op
    assign in_mul = bus.alu_op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    assign in_div = bus.alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign in_sgn = bus.alu_op inside {ALU_DIV, ALU_REM};
    assign in_quo = bus.alu_op inside {ALU_DIV, ALU_DIVU};
    assign op_sgn = op_q inside {ALU_DIV, ALU_REM};
    assign op_quo = op_q inside {ALU_DIV, ALU_DIVU};
    assign q_neg  = op_sgn & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    assign r_neg  = op_sgn & a_q[XLEN-1];

    // Multiplier: operands widened by one bit so a single signed product covers all four flavours
    always_comb begin
        mul_a = {(op_q inside {ALU_MULH, ALU_MULHSU}) & a_q[XLEN-1], a_q};
        mul_b = {(op_q == ALU_MULH) & b_q[XLEN-1], b_q};
        prod  = PW'(mul_a) * PW'(mul_b);
    end

    // Divider step: shift the next dividend bit into the partial remainder and trial-compare
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, dvs_q};

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_d = bus.alu_op;
                        a_d  = bus.rs1;
                        b_d  = bus.rs2;
                        if (in_mul) begin
                            state_d = S_MUL;
                        end else if (in_div) begin
                            if (bus.rs2 == '0) begin
                                state_d  = S_DONE;
                                result_d = in_quo ? ALL_ONES : bus.rs1;
                            end else if (in_sgn && bus.rs1 == MIN_NEG && bus.rs2 == ALL_ONES) begin
                                state_d  = S_DONE;
                                result_d = in_quo ? MIN_NEG : '0;
                            end else begin
                                state_d = S_DIV;
                                quo_d   = (in_sgn && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
                                dvs_d   = (in_sgn && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
                                rem_d   = '0;
                                cnt_d   = CNT_W'(XLEN);
                            end
                        end else begin
                            state_d  = S_DONE;
                            result_d = '0;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    result_d = (op_q == ALU_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
                    state_d  = S_DONE;
                end
                S_DIV: begin
                    if (rem_ge) begin
                        rem_d = XLEN'(rem_shift - {1'b0, dvs_q});
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (op_quo) begin
                        result_d = q_neg ? -quo_q : quo_q;
                    end else begin
                        result_d = r_neg ? -rem_q : rem_q;
                    end
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= state_d inside {S_MUL, S_DIV, S_FIXUP};
            done_q   <= state_d == S_DONE;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed RV32M ops against a plain-arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;
    logic [31:0] last_exp = '0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference results straight from the RV32M definitions using wide integer arithmetic
    function automatic logic [31:0] model_res(alu_op_e op, logic [31:0] a, logic [31:0] b);
        longint          sa  = $signed(a);
        longint          sb  = $signed(b);
        longint unsigned ua  = {32'h0, a};
        longint unsigned ub  = {32'h0, b};
        int              sa32 = $signed(a);
        int              sb32 = $signed(b);
        logic [63:0]     p;
        case (op)
            ALU_MUL:    begin p = sa * sb; return p[31:0]; end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
            ALU_DIV: begin
                if (b == 0) return ALL_ONES;
                if (a == MIN_NEG && b == ALL_ONES) return MIN_NEG;
                return sa32 / sb32;
            end
            ALU_REM: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == ALL_ONES) return 32'h0;
                return sa32 % sb32;
            end
            ALU_DIVU: return (b == 0) ? ALL_ONES : a / b;
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    // Start-edge-to-done latency in cycles
    function automatic int model_lat(alu_op_e op, logic [31:0] a, logic [31:0] b);
        if (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return 2;
        if (op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
            if (b == 0) return 1;
            if (op inside {ALU_DIV, ALU_REM} && a == MIN_NEG && b == ALL_ONES) return 1;
            return XLEN + 2;
        end
        return 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                n_done++;
                if (sbq.size() == 0) begin
                    check("unexpected_done", 64'(bus.result), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = sbq.pop_front();
                    check("result", 64'(bus.result), 64'(e.res));
                    check("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Drive a request for the next edge; optionally register the expected response
    task automatic drive_start(alu_op_e op, logic [31:0] a, logic [31:0] b, bit push);
        exp_t e;
        bus.alu_op = op;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.start  = 1'b1;
        if (push) begin
            e.res = model_res(op, a, b);
            e.cyc = cyc + 1 + model_lat(op, a, b) - 1;
            sbq.push_back(e);
            last_exp = e.res;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int bc);
        int n = 0;
        bc = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy === 1'b1) bc++;
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.done !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
    endtask

    task automatic run_op(alu_op_e op, logic [31:0] a, logic [31:0] b);
        int bc;
        @(negedge clk);
        drive_start(op, a, b, 1'b1);
        wait_done(bc);
        check("busy_cycles", 64'(bc), 64'(model_lat(op, a, b) - 1));
    endtask

    initial begin
        int          bc;
        int          dcount;
        alu_op_e     op;
        logic [31:0] a, b;

        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.alu_op = ALU_ADD;
        bus.rs1    = '0;
        bus.rs2    = '0;

        #1;
        check("reset_busy",   64'(bus.busy),   64'h0);
        check("reset_done",   64'(bus.done),   64'h0);
        check("reset_result", 64'(bus.result), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(ALU_MUL,    32'd7,        32'hFFFF_FFF9);
        run_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000);
        run_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(ALU_DIV,    32'hFFFF_FFF9, 32'd2);
        run_op(ALU_REM,    32'hFFFF_FFF9, 32'd2);
        run_op(ALU_DIVU,   32'd100,      32'd7);
        run_op(ALU_REMU,   32'd100,      32'd7);
        run_op(ALU_DIVU,   32'd5,        32'd0);
        run_op(ALU_REM,    32'd5,        32'd0);
        run_op(ALU_DIV,    MIN_NEG,      ALL_ONES);
        run_op(ALU_REM,    MIN_NEG,      ALL_ONES);
        run_op(ALU_ADD,    32'd3,        32'd4);

        // Explicit back-to-back: second start presented during the DONE cycle
        run_op(ALU_DIVU, 32'd1000, 32'd33);
        drive_start(ALU_MUL, 32'd12345, 32'd678, 1'b1);
        wait_done(bc);
        check("b2b_busy_cycles", 64'(bc), 64'd1);

        // Start pulsed while dividing is ignored
        @(negedge clk);
        drive_start(ALU_DIV, 32'hFFFF_FC18, 32'd7, 1'b1);
        repeat (3) @(negedge clk);
        bus.start  = 1'b1;
        bus.alu_op = ALU_MUL;
        bus.rs1    = 32'd9;
        bus.rs2    = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc);

        // Flush mid-divide, then flush together with start while idle
        dcount = n_done;
        @(negedge clk);
        drive_start(ALU_DIVU, 32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (8) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.alu_op = ALU_DIVU;
        bus.rs1    = 32'd5;
        bus.rs2    = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("flush_busy",    64'(bus.busy),   64'h0);
        check("flush_result",  64'(bus.result), 64'(last_exp));
        check("flush_no_done", 64'(n_done),     64'(dcount));

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        drive_start(ALU_REM, 32'h1234_5678, 32'h0000_0ABC, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   64'(bus.busy),   64'h0);
        check("arst_done",   64'(bus.done),   64'h0);
        check("arst_result", 64'(bus.result), 64'h0);
        last_exp = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = n_done;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_done", 64'(n_done), 64'(dcount));

        // Randomized traffic with boundary-biased operands
        for (int i = 0; i < 150; i++) begin
            op = alu_op_e'($urandom_range(0, 17));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = MIN_NEG; b = ALL_ONES; end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
                3: b = $urandom_range(1, 7) | (b & 32'h8000_0000);
                default: ;
            endcase
            run_op(op, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sbq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
